// File: rtl/product_display_ctrl.sv
// Shows a signed product on a four-digit seven-segment display: a sign slot plus a three-digit window.
// The magnitude is converted to BCD with a sequential shift-add-3 engine, one bit per clock.
module product_display_ctrl #(
  parameter int WIDTH       = 16,
  parameter int REFRESH_CNT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] product,
  input  logic             scroll_up,
  input  logic             scroll_down,
  output logic [1:0]       en,
  output logic [3:0]       num,
  output logic             busy,
  output logic             done
);

  localparam int NDIG_RAW = (WIDTH * 301) / 1000 + 1;
  localparam int NDIG     = (NDIG_RAW < 5) ? 5 : NDIG_RAW;
  localparam int BW       = 4 * NDIG;
  localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW       = $clog2(REFRESH_CNT);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    mag_reg;
  logic [BW-1:0]       bcd_reg;
  logic [CW-1:0]       iter_reg;
  logic                sign_pend_reg;
  logic                sign_reg;
  logic [3:0]          digit_reg [5];
  logic [RW-1:0]       refresh_reg;
  logic [1:0]          offset_reg;

  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [WIDTH-1:0]    abs_product;
  logic [2:0]          idx;

  // Add-3 correction on every nibble before the shift.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign shifted = {bcd_adj, mag_reg} << 1;
  // The most negative value negates to itself, which read as unsigned is exactly its magnitude.
  assign abs_product = product[WIDTH-1] ? (~product + 1'b1) : product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      mag_reg       <= '0;
      bcd_reg       <= '0;
      iter_reg      <= '0;
      sign_pend_reg <= 1'b0;
      sign_reg      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < 5; i++) digit_reg[i] <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            mag_reg       <= abs_product;
            sign_pend_reg <= product[WIDTH-1];
            bcd_reg       <= '0;
            iter_reg      <= '0;
            busy          <= 1'b1;
            state_reg     <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_reg <= shifted[BW+WIDTH-1:WIDTH];
          mag_reg <= shifted[WIDTH-1:0];
          if (iter_reg == CW'(WIDTH - 1)) state_reg <= UPDATE;
          else iter_reg <= iter_reg + 1'b1;
        end
        UPDATE: begin
          for (int i = 0; i < 5; i++) digit_reg[i] <= bcd_reg[4*i +: 4];
          sign_reg  <= sign_pend_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_reg <= '0;
      en          <= 2'd0;
    end else if (refresh_reg == RW'(REFRESH_CNT - 1)) begin
      refresh_reg <= '0;
      en          <= en + 2'd1;
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_reg <= 2'd0;
    end else if (scroll_up && !scroll_down && offset_reg != 2'd2) begin
      offset_reg <= offset_reg + 2'd1;
    end else if (scroll_down && !scroll_up && offset_reg != 2'd0) begin
      offset_reg <= offset_reg - 2'd1;
    end
  end

  // Slot 1 is the most significant digit of the window, slot 3 the least.
  always_comb begin
    idx = {1'b0, offset_reg} + (3'd3 - {1'b0, en});
    if (en == 2'd0) num = sign_reg ? 4'd10 : 4'd15;
    else            num = digit_reg[idx];
  end

endmodule
